// File: rtl/pipeline_flow_controller.sv
// Front-end sequencer: resolves hazard PC/stall requests and runs the boot and
// interrupt-entry sequences (drain, PC/CCR push, vector fetch).
module pipeline_flow_controller #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bubble_req,
    input  logic [1:0] pc_src_hz,
    input  logic       int_req,
    input  logic       rti_dec,
    output logic [1:0] pc_src,
    output logic       vec_sel,
    output logic       pc_we,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       push_valid,
    output logic       push_sel,
    output logic       int_ack,
    output logic       in_isr
);

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        DRAIN,
        PUSH_PC,
        PUSH_CCR,
        VECTOR
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_HOLD   = 2'b10;
    localparam logic [1:0] PC_VECTOR = 2'b11;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] drain_cnt, drain_cnt_next;
    logic       int_pending;
    logic       int_req_d;
    logic       in_isr_q, in_isr_next;
    logic       pend_clr;
    logic       int_edge;
    logic       hz_branch;
    logic       hz_hold;

    assign int_edge  = int_req & ~int_req_d;
    assign hz_branch = (pc_src_hz == PC_BRANCH);
    assign hz_hold   = (pc_src_hz == PC_HOLD);
    assign in_isr    = in_isr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            drain_cnt   <= '0;
            int_pending <= 1'b0;
            in_isr_q    <= 1'b0;
            int_req_d   <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            int_req_d   <= int_req;
            // A new edge on the vector-fetch cycle survives the clear.
            int_pending <= int_edge | (int_pending & ~pend_clr);
            in_isr_q    <= in_isr_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        in_isr_next    = in_isr_q;
        pend_clr       = 1'b0;
        pc_src         = PC_SEQ;
        vec_sel        = 1'b0;
        pc_we          = 1'b0;
        if_id_en       = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        push_valid     = 1'b0;
        push_sel       = 1'b0;
        int_ack        = 1'b0;

        unique case (state)
            BOOT: begin
                pc_src      = PC_VECTOR;
                pc_we       = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_next  = RUN;
            end

            RUN: begin
                pc_src   = PC_SEQ;
                pc_we    = 1'b1;
                if_id_en = 1'b1;
                if (rti_dec && in_isr_q) begin
                    in_isr_next = 1'b0;
                end
                if (int_pending && !in_isr_q && !bubble_req && !hz_branch) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else if (hz_branch) begin
                    pc_src      = PC_BRANCH;
                    if_id_flush = 1'b1;
                end else if (bubble_req || hz_hold) begin
                    pc_src      = PC_HOLD;
                    pc_we       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            DRAIN: begin
                pc_src      = PC_HOLD;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                if (drain_cnt == 3'd0) begin
                    state_next = PUSH_PC;
                end else begin
                    drain_cnt_next = drain_cnt - 3'd1;
                end
            end

            PUSH_PC: begin
                pc_src      = PC_HOLD;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                push_valid  = 1'b1;
                push_sel    = 1'b0;
                state_next  = PUSH_CCR;
            end

            PUSH_CCR: begin
                pc_src      = PC_HOLD;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                push_valid  = 1'b1;
                push_sel    = 1'b1;
                state_next  = VECTOR;
            end

            VECTOR: begin
                pc_src      = PC_VECTOR;
                vec_sel     = 1'b1;
                pc_we       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                int_ack     = 1'b1;
                in_isr_next = 1'b1;
                pend_clr    = 1'b1;
                state_next  = RUN;
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: doc/pipeline_flow_controller.md
# pipeline_flow_controller

Central sequencer for the 5-stage pipeline's front end. It takes the hazard unit's load-use bubble and branch PC-source requests, an external interrupt pin, and the RTI decode. It produces the single resolved PC-source select, PC write enable, and IF/ID and ID/EX stall/flush controls. It also runs the multi-cycle boot and interrupt-entry sequences, including pipeline drain, PC/CCR push and vector fetch, so the datapath never sees conflicting control.

## Interface
- DRAIN_CYCLES, 3: cycles IF/ID is flushed and PC held before the first interrupt push (range 1..7).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- bubble_req  input  1  load-use stall request from hazard detection.
- pc_src_hz  input  2  hazard PC request: 00 sequential, 01 branch target, 10 hold (treated as stall), 11 reserved (treated as 00).
- int_req  input  1  external interrupt, level; a rising edge is latched.
- rti_dec  input  1  RTI decoded in ID this cycle.
- pc_src  output  2  00 PC+1, 01 branch target, 10 hold, 11 vector.
- vec_sel  output  1  0 reset vector (M[0]), 1 interrupt vector (M[1]); meaningful only when pc_src=11.
- pc_we  output  1  PC register write enable.
- if_id_en  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID cleared to NOP.
- id_ex_flush  output  1  ID/EX cleared to NOP (bubble).
- push_valid  output  1  memory stage performs an interrupt push this cycle.
- push_sel  output  1  0 push PC, 1 push CCR.
- int_ack  output  1  one-cycle pulse on vector fetch.
- in_isr  output  1  high from vector fetch until RTI is accepted.

## Operation
- States: BOOT, RUN, DRAIN, PUSH_PC, PUSH_CCR, VECTOR.
- Registers: state, drain counter (3 bits), int_pending, in_isr, int_req_d (edge detect).
- Reset (rst=0, asynchronous): state=BOOT, counter=0, int_pending=0, in_isr=0, int_req_d=0.
- BOOT outputs: pc_src=11, vec_sel=0, pc_we=1, if_id_flush=1, id_ex_flush=1, all others 0. BOOT always goes to RUN on the next edge.
- RUN priority, highest first:
  1. Interrupt entry if int_pending=1, in_isr=0, bubble_req=0, and pc_src_hz≠01. Go to DRAIN, load counter=DRAIN_CYCLES-1. No PC/flush action this cycle beyond sequential fetch.
  2. Branch if pc_src_hz=01: pc_src=01, pc_we=1, if_id_flush=1, if_id_en=1.
  3. Stall if bubble_req=1 or pc_src_hz=10: pc_src=10, pc_we=0, if_id_en=0, id_ex_flush=1.
  4. Otherwise: pc_src=00, pc_we=1, if_id_en=1, all flushes 0.
- RUN default, when no case above drives them: pc_src=00, pc_we=1, if_id_en=1.
- DRAIN: pc_src=10, pc_we=0, if_id_flush=1, if_id_en=1, id_ex_flush=0. Counter decrements each cycle; at 0, go to PUSH_PC.
- PUSH_PC: push_valid=1, push_sel=0, PC held, IF/ID flushed. Go to PUSH_CCR.
- PUSH_CCR: push_valid=1, push_sel=1, PC held, IF/ID flushed. Go to VECTOR.
- VECTOR: pc_src=11, vec_sel=1, pc_we=1, if_id_flush=1, int_ack=1. Set in_isr=1, clear int_pending. Go to RUN.
- int_pending is set on any clock where int_req=1 and int_req_d=0. Edges seen while pending or while in_isr=1 are merged into one pending request; nesting is disallowed. A set and a clear on the same edge (VECTOR cycle) resolve as set.
- RTI: rti_dec=1 in RUN with in_isr=1 clears in_isr on the next edge. rti_dec with in_isr=0 is ignored. The PC/CCR restore itself is done by the RTI datapath; this block only tracks state.
- All outputs are combinational from state, plus the RUN-state inputs. No output depends on int_req directly.

## Timing
- Branch redirect: same cycle as pc_src_hz=01. Exactly one fetched instruction is flushed.
- Load-use stall: one cycle per asserted bubble_req cycle. Back-to-back requests give back-to-back stalls.
- Interrupt latency from the accepting RUN cycle to vector write: DRAIN_CYCLES+3 cycles. int_ack is asserted on cycle DRAIN_CYCLES+3.
- Interrupt edge arriving during DRAIN..VECTOR, or while in_isr=1: held pending and taken in the first eligible RUN cycle after RTI.
- Branch or bubble coincident with a pending interrupt: the branch/stall is served first, and the interrupt is taken no earlier than the next cycle.
- rst asserted mid-sequence (e.g. in PUSH_CCR): immediate return to BOOT outputs. Pending and in_isr are lost.

## Test plan
- Reset release: rst 0→1. Cycle 0 shows pc_src=11, vec_sel=0, pc_we=1, both flushes=1. Cycle 1 is RUN with pc_src=00, pc_we=1.
- Load-use: bubble_req=1 for 2 cycles gives pc_src=10, pc_we=0, if_id_en=0, id_ex_flush=1 for exactly 2 cycles, then sequential.
- Branch: pc_src_hz=01 for 1 cycle gives pc_src=01, pc_we=1, if_id_flush=1 that cycle only.
- Interrupt, DRAIN_CYCLES=3: int_req rises in RUN. Expect 3 DRAIN cycles (pc_we=0, if_id_flush=1), then push_sel=0 then 1 with push_valid=1, then pc_src=11, vec_sel=1, int_ack=1, and in_isr=1 thereafter.
- Nesting: second int_req edge while in_isr=1 gives no entry. rti_dec=1 clears in_isr, then the entry starts on the following RUN cycle.
- Priority/reset: int_pending with pc_src_hz=01 in the same cycle means the branch is taken and DRAIN is entered the next cycle. rst pulsed low during PUSH_PC gives BOOT outputs immediately with in_isr=0 and no int_ack.
